load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Core-side initiator for the RV32I data memory. Accepts one load/store per request and
//  decodes funct3 width/sign. Drives a word-aligned, word-only memory port: combinational
//  read, one-cycle synchronous write, little-endian bytes. SB/SH are done as
//  read-modify-write. Misaligned or illegal accesses raise lsu_fault and never touch memory.
// PARAMETERS
//  XLEN  32  data/address width; only 32 is supported
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  lsu_req      in   1   request; sampled only in IDLE
//  lsu_we       in   1   1 = store, 0 = load
//  lsu_funct3   in   3   load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store: 000 SB, 001 SH, 010 SW
//  lsu_addr     in   32  byte address
//  lsu_wdata    in   32  store data; low byte/half used for SB/SH
//  lsu_busy     out  1   state != IDLE; pipeline stall
//  lsu_done     out  1   1-cycle pulse: access complete
//  lsu_rdata    out  32  load result, valid with done, held until next done
//  lsu_fault    out  1   valid with done: misaligned or illegal funct3
//  mem_addr     out  32  {addr_q[31:2],2'b00} in RD/WR; 0 otherwise
//  mem_wdata    out  32  write word in WR; 0 otherwise
//  mem_we       out  1   1 only in WR state (combinational from state)
//  mem_rdata    in   32  word at mem_addr, combinational
// BEHAVIOUR
//  States: IDLE, RD, WR, DONE. Reset: state IDLE; all outputs 0.
//  Accept: IDLE & lsu_req -> register we, funct3, addr, wdata. Ignore req in any other state.
//  Fault check at accept:
//   - LH/LHU/SH with addr[0]!=0 is misaligned.
//   - LW/SW with addr[1:0]!=0 is misaligned.
//   - Load funct3 011/110/111 and store funct3 >=011 are illegal.
//   - On fault: IDLE->DONE, fault=1, rdata=0, no memory access.
//  Transitions:
//   - Load: IDLE->RD->DONE.
//   - SW: IDLE->WR->DONE.
//   - SB/SH: IDLE->RD->WR->DONE.
//   - DONE->IDLE always.
//  Latency from accept edge to done-high cycle: fault 1; load 2; SW 2; SB/SH 3.
//   A new req is accepted in the cycle after DONE.
//  RD: mem_addr driven; word captured into word_q at the next edge.
//  Load extract, off=addr_q[1:0]:
//   - byte = word_q[8*off+:8]; half = word_q[16*off[1]+:16].
//   - LB/LH sign-extend; LBU/LHU zero-extend; LW returns the word.
//   - lsu_rdata is registered at RD->DONE.
//  Store merge in WR:
//   - SB replaces byte lane off with wdata[7:0]; SH replaces half lane off[1] with wdata[15:0].
//   - Other lanes come from word_q; SW writes wdata whole.
//  Stores: lsu_rdata unchanged; fault=0 on success.
//  lsu_done and lsu_fault are high only in DONE; fault=0 on success.
//  Reset mid-operation: immediate IDLE; mem_we and busy drop without waiting for a clock
//   edge; no partial write after reset.
//  Address wrap: none; addr_q[31:2] is passed through unchanged (0xFFFF_FFFC is legal).
// TESTING
//  1 mem[0x100]=0x87654321. LB 0x103 -> rdata 0xFFFFFF87, done 2 cycles after accept.
//    LBU 0x103 -> 0x00000087.
//  2 Same word. LH 0x102 -> 0xFFFF8765. LHU 0x100 -> 0x00004321. LW 0x100 -> 0x87654321. fault=0.
//  3 SB 0x101, wdata 0xAAAAAA5A -> word becomes 0x87655A21; mem_we high exactly 1 cycle;
//    done 3 cycles after accept.
//  4 SW 0x200 0xDEADBEEF -> no RD state; one write of 0xDEADBEEF at 0x200; done 2 cycles;
//    SH 0x202 0x1234 -> word becomes 0x1234BEEF.
//  5 LW 0x102 -> done+fault 1 cycle after accept, rdata 0, mem_we never 1.
//    Load funct3 011 -> fault. SB at any offset -> no fault.
//  6 Raise rst in the WR cycle of an SH -> mem_we 0 immediately, word unchanged, busy 0.
//    req held high while busy -> exactly one access performed.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: RV32I data-memory initiator with funct3 width/sign decode,
// sub-word stores via read-modify-write and fault detection at accept time.
module load_store_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lsu_req_i,
  input  logic            lsu_we_i,
  input  logic [2:0]      lsu_funct3_i,
  input  logic [XLEN-1:0] lsu_addr_i,
  input  logic [XLEN-1:0] lsu_wdata_i,
  output logic            lsu_busy_o,
  output logic            lsu_done_o,
  output logic [XLEN-1:0] lsu_rdata_o,
  output logic            lsu_fault_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic            mem_we_o,
  input  logic [XLEN-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

  state_e          state_q;
  logic            we_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] word_q;
  logic [XLEN-1:0] rdata_q;
  logic            fault_q;

  logic            fault_d;
  logic            illegal_d;
  logic            misalign_d;
  logic [1:0]      off_d;
  logic [7:0]      byte_d;
  logic [15:0]     half_d;
  logic [XLEN-1:0] load_d;
  logic [XLEN-1:0] merge_d;

  // Classify the incoming request: unsupported funct3 or a width-misaligned address
  always_comb begin
    illegal_d  = 1'b0;
    misalign_d = 1'b0;
    if (lsu_we_i) begin
      illegal_d = (lsu_funct3_i > 3'b010);
    end else begin
      illegal_d = (lsu_funct3_i == 3'b011) || (lsu_funct3_i == 3'b110) ||
                  (lsu_funct3_i == 3'b111);
    end
    if (lsu_funct3_i[1:0] == 2'b01) begin
      misalign_d = lsu_addr_i[0];
    end else if (lsu_funct3_i[1:0] == 2'b10) begin
      misalign_d = (lsu_addr_i[1:0] != 2'b00);
    end
    fault_d = illegal_d | misalign_d;
  end

  // Pick the addressed lane out of the word being read and extend it to XLEN
  always_comb begin
    off_d  = addr_q[1:0];
    byte_d = mem_rdata_i[{off_d, 3'b000} +: 8];
    half_d = mem_rdata_i[{off_d[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  load_d = {{(XLEN-8){byte_d[7]}}, byte_d};
      3'b001:  load_d = {{(XLEN-16){half_d[15]}}, half_d};
      3'b100:  load_d = {{(XLEN-8){1'b0}}, byte_d};
      3'b101:  load_d = {{(XLEN-16){1'b0}}, half_d};
      default: load_d = mem_rdata_i;
    endcase
  end

  // Build the write word: sub-word stores keep the untouched lanes of the captured word
  always_comb begin
    merge_d = word_q;
    case (funct3_q[1:0])
      2'b00:   merge_d[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
      2'b01:   merge_d[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merge_d = wdata_q;
    endcase
  end

  // Access sequencer: accept in IDLE, optional read, optional write, one-cycle DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      word_q   <= '0;
      rdata_q  <= '0;
      fault_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (lsu_req_i) begin
            we_q     <= lsu_we_i;
            funct3_q <= lsu_funct3_i;
            addr_q   <= lsu_addr_i;
            wdata_q  <= lsu_wdata_i;
            fault_q  <= fault_d;
            if (fault_d) begin
              rdata_q <= '0;
              state_q <= DONE;
            end else if (lsu_we_i && (lsu_funct3_i[1:0] == 2'b10)) begin
              state_q <= WR;
            end else begin
              state_q <= RD;
            end
          end
        end
        RD: begin
          word_q <= mem_rdata_i;
          if (we_q) begin
            state_q <= WR;
          end else begin
            rdata_q <= load_d;
            state_q <= DONE;
          end
        end
        WR:      state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lsu_busy_o  = (state_q != IDLE);
  assign lsu_done_o  = (state_q == DONE);
  assign lsu_fault_o = (state_q == DONE) & fault_q;
  assign lsu_rdata_o = rdata_q;
  assign mem_we_o    = (state_q == WR);
  assign mem_addr_o  = ((state_q == RD) || (state_q == WR)) ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign mem_wdata_o = (state_q == WR) ? merge_d : '0;

endmodule
